// File: rtl/restador_serie.sv
// Bit-serial unsigned subtractor: A - B one bit per clock, LSB first,
// with a single borrow flop and a start/done handshake.
module restador_serie #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Inicio,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Resta,
  output logic         Bout,
  output logic         Listo,
  output logic         Ocupado
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    REPOSO,
    DESPLAZA,
    FIN
  } estadoT;

  estadoT estado, estadoSig;

  logic [N-1:0]  regA, regB, regD;
  logic          borrow;
  logic [CW-1:0] contador;

  logic bitA, bitB, difBit, borrowSig, ultimo;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    bitA      = regA[0];
    bitB      = regB[0];
    difBit    = bitA ^ bitB ^ borrow;
    borrowSig = (~bitA & bitB) | (~(bitA ^ bitB) & borrow);
    ultimo    = (contador == CW'(N - 1));
  end

  always_comb begin
    estadoSig = estado;
    case (estado)
      REPOSO:   if (Inicio) estadoSig = DESPLAZA;
      DESPLAZA: if (ultimo) estadoSig = FIN;
      FIN:      estadoSig = REPOSO;
      default:  estadoSig = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) estado <= REPOSO;
    else     estado <= estadoSig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regA     <= '0;
      regB     <= '0;
      regD     <= '0;
      borrow   <= 1'b0;
      contador <= '0;
      Resta    <= '0;
      Bout     <= 1'b0;
      Listo    <= 1'b0;
      Ocupado  <= 1'b0;
    end else begin
      // Listo/Ocupado are registered copies of the next state so the
      // outputs carry no combinational path from the inputs.
      Listo   <= (estado == DESPLAZA) && ultimo;
      Ocupado <= (estadoSig != REPOSO);
      case (estado)
        REPOSO: begin
          if (Inicio) begin
            regA     <= A;
            regB     <= B;
            regD     <= '0;
            borrow   <= 1'b0;
            contador <= '0;
          end
        end
        DESPLAZA: begin
          regA     <= {1'b0, regA[N-1:1]};
          regB     <= {1'b0, regB[N-1:1]};
          regD     <= {difBit, regD[N-1:1]};
          borrow   <= borrowSig;
          contador <= contador + CW'(1);
          if (ultimo) begin
            Resta <= {difBit, regD[N-1:1]};
            Bout  <= borrowSig;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restador_serie.sv
// Scoreboard bench for restador_serie: N=8 and N=13 instances, directed
// cases plus a random sweep checked against plain (A-B) mod 2^N arithmetic.
module tb_restador_serie;

  typedef struct {
    longint r;
    bit     b;
    longint due;
  } expT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ini [2];
  logic [31:0] inA [2];
  logic [31:0] inB [2];

  logic [7:0]  resta0;
  logic [12:0] resta1;
  logic        bout0, bout1, listo0, listo1, ocup0, ocup1;

  int     nTests = 0;
  int     nFail  = 0;
  longint cyc    = 0;
  expT    q0[$];
  expT    q1[$];
  longint lastR [2];
  bit     lastB [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  restador_serie #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .Inicio(ini[0]), .A(inA[0][7:0]), .B(inB[0][7:0]),
    .Resta(resta0), .Bout(bout0), .Listo(listo0), .Ocupado(ocup0)
  );

  restador_serie #(.N(13)) dut13 (
    .clk(clk), .rst(rst), .Inicio(ini[1]), .A(inA[1][12:0]), .B(inB[1][12:0]),
    .Resta(resta1), .Bout(bout1), .Listo(listo1), .Ocupado(ocup1)
  );

  task automatic check(input string nm, input int k, input longint act, input longint expv);
    nTests++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s[N=%0d] cyc=%0d: got %0d, expected %0d", nm, k ? 13 : 8, cyc, act, expv);
    end
  endtask

  function automatic int qSize(input int k);
    return k ? q1.size() : q0.size();
  endfunction

  function automatic expT qFront(input int k);
    return k ? q1[0] : q0[0];
  endfunction

  task automatic qPop(input int k);
    if (k) void'(q1.pop_front());
    else   void'(q0.pop_front());
  endtask

  task automatic qPush(input int k, input expT e);
    if (k) q1.push_back(e);
    else   q0.push_back(e);
  endtask

  task automatic flushModel();
    q0.delete();
    q1.delete();
    lastR[0] = 0; lastR[1] = 0;
    lastB[0] = 0; lastB[1] = 0;
  endtask

  function automatic logic ocup(input int k);
    return k ? ocup1 : ocup0;
  endfunction

  function automatic expT model(input int k, input longint a, input longint b, input longint due);
    longint w = k ? 13 : 8;
    longint m = (longint'(1) << w) - 1;
    expT e;
    e.r   = (a - b) & m;
    e.b   = (a < b);
    e.due = due;
    return e;
  endfunction

  // Monitor: pops on every Listo; between completions the outputs must hold.
  task automatic monCheck(input int k, input logic l, input longint r, input logic b);
    expT e;
    if (l) begin
      if (qSize(k) == 0) begin
        check("listo_unexpected", k, 1, 0);
      end else begin
        e = qFront(k);
        qPop(k);
        check("resta", k, r, e.r);
        check("bout", k, longint'(b), longint'(e.b));
        check("latency", k, cyc, e.due);
        lastR[k] = e.r;
        lastB[k] = e.b;
      end
    end else begin
      check("resta_hold", k, r, lastR[k]);
      check("bout_hold", k, longint'(b), longint'(lastB[k]));
      if (qSize(k) != 0) begin
        e = qFront(k);
        if (cyc > e.due) begin
          check("listo_missing", k, 0, 1);
          qPop(k);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      monCheck(0, listo0, longint'(resta0), bout0);
      monCheck(1, listo1, longint'(resta1), bout1);
    end
  end

  // One operation; poke re-asserts Inicio mid-operation (must be ignored).
  task automatic doOp(input int k, input logic [31:0] a, input logic [31:0] b, input bit poke);
    int     w = k ? 13 : 8;
    longint m = (longint'(1) << w) - 1;
    longint aa = longint'(a) & m;
    longint bb = longint'(b) & m;
    longint e0;
    inA[k] = a;
    inB[k] = b;
    ini[k] = 1'b1;
    e0 = cyc + 1;
    qPush(k, model(k, aa, bb, e0 + w));
    @(negedge clk);
    ini[k] = 1'b0;
    check("ocupado", k, longint'(ocup(k)), 1);
    for (int i = 1; i <= w + 1; i++) begin
      inA[k] = $urandom;
      inB[k] = $urandom;
      ini[k] = poke && (i == 2 || i == 5);
      @(negedge clk);
      check("ocupado", k, longint'(ocup(k)), (i <= w) ? 1 : 0);
    end
    ini[k] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    longint e0;
    ini[0] = 0; ini[1] = 0;
    inA[0] = 0; inA[1] = 0; inB[0] = 0; inB[1] = 0;
    flushModel();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ocupado", 0, longint'(ocup0), 0);
    check("reset_listo", 0, longint'(listo0), 0);
    check("reset_resta", 0, longint'(resta0), 0);
    check("reset_bout", 0, longint'(bout0), 0);
    check("reset_ocupado", 1, longint'(ocup1), 0);
    check("reset_resta", 1, longint'(resta1), 0);
    rst = 1'b0;
    @(negedge clk);

    doOp(0, 100, 37, 0);
    doOp(0, 5, 10, 0);
    doOp(0, 0, 255, 0);
    doOp(0, 255, 255, 0);
    doOp(0, 0, 0, 0);
    doOp(0, 200, 1, 1);

    // Inicio held high for 30 edges: three back-to-back operations.
    inA[0] = 9; inB[0] = 3; ini[0] = 1'b1;
    e0 = cyc + 1;
    for (int j = 0; j < 3; j++) qPush(0, model(0, 9, 3, e0 + 10 * j + 8));
    repeat (30) @(negedge clk);
    ini[0] = 1'b0;
    @(negedge clk);

    // Reset during cycle 4 of an operation aborts it without Listo.
    inA[0] = 50; inB[0] = 20; ini[0] = 1'b1;
    qPush(0, model(0, 50, 20, cyc + 9));
    @(negedge clk);
    ini[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    flushModel();
    @(negedge clk);
    check("abort_ocupado", 0, longint'(ocup0), 0);
    check("abort_listo", 0, longint'(listo0), 0);
    check("abort_resta", 0, longint'(resta0), 0);
    check("abort_bout", 0, longint'(bout0), 0);
    rst = 1'b0;
    @(negedge clk);
    doOp(0, 17, 17, 0);

    fork
      for (int i = 0; i < 1000; i++) doOp(0, $urandom, $urandom, ($urandom_range(0, 7) == 0));
      for (int i = 0; i < 1000; i++) doOp(1, $urandom, $urandom, ($urandom_range(0, 7) == 0));
    join

    repeat (4) @(negedge clk);
    check("pending_results", 0, longint'(q0.size()), 0);
    check("pending_results", 1, longint'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
